// File: rtl/uart_rx_core_v2.sv
// Oversampling UART receiver in the sys_clk domain: 3-point majority sampling,
// configurable frame format, break detection and a valid/ready output register.
module uart_rx_core_v2 #(
    parameter int SYS_CLK_FREQ = 200_000_000,
    parameter int BAUD_RATE    = 19200,
    parameter int OVERSAMPLE   = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 uart_rx_din,
    output logic [DATA_BITS-1:0] uart_rx_dout,
    output logic                 uart_rx_valid,
    input  logic                 uart_rx_ready,
    output logic                 uart_rx_parity_error,
    output logic                 uart_rx_frame_error,
    output logic                 uart_rx_overrun,
    output logic                 uart_rx_break,
    output logic                 uart_rx_busy
);

    localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_M0      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_M1      = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx_core_v2: SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
            (PARITY_MODE < 0) || (PARITY_MODE > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_fmt
            $error("uart_rx_core_v2: unsupported frame format parameters");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    function automatic logic f_parity_ok(input logic [DATA_BITS-1:0] data, input logic p);
        logic x;
        x = ^{data, p};
        if (PARITY_MODE == 1) begin
            return x;
        end else if (PARITY_MODE == 2) begin
            return ~x;
        end else begin
            return 1'b1;
        end
    endfunction

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1, r_sync2, r_sync3;
    logic [TW-1:0]        r_tick_cnt;
    logic [SW-1:0]        r_s;
    logic [SW-1:0]        r_hi_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_m0, r_m1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_p, r_ferr_p, r_any_one;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_valid, r_perr, r_ferr, r_ovr, r_brk, r_busy;

    logic w_fall, w_tick, w_bit, w_dec, w_wrap;
    logic w_complete, w_break, w_ferr_final;

    assign w_fall = r_sync3 & ~r_sync2;
    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_bit  = (r_m0 & r_m1) | (r_m0 & r_sync2) | (r_m1 & r_sync2);
    assign w_dec  = w_tick && (r_s == S_DEC);
    assign w_wrap = w_tick && (r_s == S_LAST);

    // Frame state register
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and frame-completion strobes
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_break      = 1'b0;
        w_ferr_final = r_ferr_p;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_next = ST_START;
                else        w_state_next = ST_IDLE;
            end
            ST_START: begin
                if (w_dec && w_bit) w_state_next = ST_IDLE;
                else if (w_wrap)    w_state_next = ST_DATA;
                else                w_state_next = ST_START;
            end
            ST_DATA: begin
                if (w_wrap && (r_bit_cnt == BIT_LAST)) begin
                    w_state_next = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_wrap) w_state_next = ST_STOP;
                else        w_state_next = ST_PARITY;
            end
            ST_STOP: begin
                // Complete at the final stop decision so the next start edge is not missed
                if (w_dec && (r_bit_cnt == STOP_LAST)) begin
                    w_complete   = 1'b1;
                    w_ferr_final = r_ferr_p | ~w_bit;
                    w_break      = ~r_any_one & ~w_bit;
                    w_state_next = (~r_any_one & ~w_bit) ? ST_BREAK_WAIT : ST_IDLE;
                end else begin
                    w_state_next = ST_STOP;
                end
            end
            ST_BREAK_WAIT: begin
                if (w_tick && r_sync2 && (r_hi_cnt == S_LAST)) w_state_next = ST_IDLE;
                else                                           w_state_next = ST_BREAK_WAIT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Input synchroniser, tick/sample timing and per-frame accumulation
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync3    <= 1'b1;
            r_tick_cnt <= '0;
            r_s        <= '0;
            r_hi_cnt   <= '0;
            r_bit_cnt  <= 4'd0;
            r_m0       <= 1'b1;
            r_m1       <= 1'b1;
            r_shift    <= '0;
            r_perr_p   <= 1'b0;
            r_ferr_p   <= 1'b0;
            r_any_one  <= 1'b0;
        end else begin
            r_sync1 <= uart_rx_din;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            if ((r_state == ST_IDLE && w_fall) || w_tick) r_tick_cnt <= '0;
            else                                           r_tick_cnt <= r_tick_cnt + TW'(1);

            if (r_state == ST_IDLE)  r_s <= '0;
            else if (w_wrap)         r_s <= '0;
            else if (w_tick)         r_s <= r_s + SW'(1);

            if (w_tick && (r_s == S_M0)) r_m0 <= r_sync2;
            if (w_tick && (r_s == S_M1)) r_m1 <= r_sync2;

            if (r_state == ST_BREAK_WAIT && w_tick) r_hi_cnt <= r_sync2 ? (r_hi_cnt + SW'(1)) : '0;
            else if (r_state != ST_BREAK_WAIT)      r_hi_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 4'd0;
                    if (w_fall) begin
                        r_perr_p  <= 1'b0;
                        r_ferr_p  <= 1'b0;
                        r_any_one <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_dec) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_any_one <= r_any_one | w_bit;
                    end
                    if (w_wrap) r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? 4'd0 : (r_bit_cnt + 4'd1);
                end
                ST_PARITY: begin
                    if (w_dec) begin
                        r_perr_p  <= ~f_parity_ok(r_shift, w_bit);
                        r_any_one <= r_any_one | w_bit;
                    end
                end
                ST_STOP: begin
                    if (w_dec) begin
                        r_ferr_p  <= r_ferr_p | ~w_bit;
                        r_any_one <= r_any_one | w_bit;
                        if (r_bit_cnt != STOP_LAST) r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: r_bit_cnt <= r_bit_cnt;
            endcase
        end
    end

    // Output holding register with valid/ready handshake, overrun and break pulses
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_brk   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ovr  <= 1'b0;
            r_brk  <= 1'b0;
            r_busy <= (w_state_next != ST_IDLE);
            if (w_complete && w_break) begin
                r_brk   <= 1'b1;
                r_valid <= r_valid & ~uart_rx_ready;
            end else if (w_complete && (!r_valid || uart_rx_ready)) begin
                r_dout  <= r_shift;
                r_perr  <= r_perr_p;
                r_ferr  <= w_ferr_final;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_ovr <= 1'b1;
            end else if (r_valid && uart_rx_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign uart_rx_dout         = r_dout;
    assign uart_rx_valid        = r_valid;
    assign uart_rx_parity_error = r_perr;
    assign uart_rx_frame_error  = r_ferr;
    assign uart_rx_overrun      = r_ovr;
    assign uart_rx_break        = r_brk;
    assign uart_rx_busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_core_v2.sv
// Directed bench for uart_rx_core_v2: three instances (8N1, 8E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_core_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       line = 1'b1;
    int         sel  = 0;
    logic       ready [3];
    logic       din   [3];
    logic [7:0] dout  [3];
    logic       valid [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       ovr   [3];
    logic       brk   [3];
    logic       busy  [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;

    int         n_acc    [3] = '{0, 0, 0};
    int         n_vhi    [3] = '{0, 0, 0};
    int         n_ovr    [3] = '{0, 0, 0};
    int         n_brk    [3] = '{0, 0, 0};
    int         rise_cyc [3] = '{0, 0, 0};
    logic [7:0] acc_dout [3];
    logic       acc_perr [3];
    logic       acc_ferr [3];
    logic       pv       [3] = '{1'b0, 1'b0, 1'b0};

    assign din[0] = (sel == 0) ? line : 1'b1;
    assign din[1] = (sel == 1) ? line : 1'b1;
    assign din[2] = (sel == 2) ? line : 1'b1;

    uart_rx_core_v2 #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                      .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .sys_clk(clk), .reset(rst), .uart_rx_din(din[0]), .uart_rx_dout(dout[0]),
        .uart_rx_valid(valid[0]), .uart_rx_ready(ready[0]), .uart_rx_parity_error(perr[0]),
        .uart_rx_frame_error(ferr[0]), .uart_rx_overrun(ovr[0]), .uart_rx_break(brk[0]),
        .uart_rx_busy(busy[0]));

    uart_rx_core_v2 #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                      .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_e1 (
        .sys_clk(clk), .reset(rst), .uart_rx_din(din[1]), .uart_rx_dout(dout[1]),
        .uart_rx_valid(valid[1]), .uart_rx_ready(ready[1]), .uart_rx_parity_error(perr[1]),
        .uart_rx_frame_error(ferr[1]), .uart_rx_overrun(ovr[1]), .uart_rx_break(brk[1]),
        .uart_rx_busy(busy[1]));

    uart_rx_core_v2 #(.SYS_CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                      .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_n2 (
        .sys_clk(clk), .reset(rst), .uart_rx_din(din[2]), .uart_rx_dout(dout[2]),
        .uart_rx_valid(valid[2]), .uart_rx_ready(ready[2]), .uart_rx_parity_error(perr[2]),
        .uart_rx_frame_error(ferr[2]), .uart_rx_overrun(ovr[2]), .uart_rx_break(brk[2]),
        .uart_rx_busy(busy[2]));

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k] && ready[k]) begin
                n_acc[k]    <= n_acc[k] + 1;
                acc_dout[k] <= dout[k];
                acc_perr[k] <= perr[k];
                acc_ferr[k] <= ferr[k];
            end
            if (valid[k]) n_vhi[k] <= n_vhi[k] + 1;
            if (valid[k] && !pv[k]) rise_cyc[k] <= cyc;
            if (ovr[k]) n_ovr[k] <= n_ovr[k] + 1;
            if (brk[k]) n_brk[k] <= n_brk[k] + 1;
            pv[k] <= valid[k];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives bits[0] first, 16 clocks each; slot 'glitch' is inverted for one clock
    task automatic send(input logic [15:0] bits, input int nbits, input int glitch);
        for (int i = 0; i < nbits * 16; i++) begin
            line = bits[i / 16] ^ ((i == glitch) ? 1'b1 : 1'b0);
            if (i == 0) t_start = cyc;
            tick(1);
        end
        line = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        line = 1'b1;
        tick(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dout[k], valid[k], perr[k], ferr[k], ovr[k], brk[k], busy[k]} !== 14'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h required 0", k,
                         {dout[k], valid[k], perr[k], ferr[k], ovr[k], brk[k], busy[k]});
            end
        end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_basic_8n1;
        int a0, v0;
        sel = 0;
        a0 = n_acc[0];
        v0 = n_vhi[0];
        send({6'd0, 1'b1, 8'hA5, 1'b0}, 10, -1);
        tick(20);
        checks++;
        if (n_acc[0] - a0 !== 1) begin failures++; $display("FAIL 8n1_accept_count: got %0d required 1", n_acc[0] - a0); end
        checks++;
        if (acc_dout[0] !== 8'hA5) begin failures++; $display("FAIL 8n1_dout: got %h required a5", acc_dout[0]); end
        checks++;
        if (acc_perr[0] !== 1'b0) begin failures++; $display("FAIL 8n1_perr: got %b required 0", acc_perr[0]); end
        checks++;
        if (acc_ferr[0] !== 1'b0) begin failures++; $display("FAIL 8n1_ferr: got %b required 0", acc_ferr[0]); end
        // 2 sync flops + 1 edge-detect + 9 bit times to the stop bit + 9 to its decision + 1 load
        checks++;
        if (rise_cyc[0] - t_start !== 157) begin failures++; $display("FAIL 8n1_latency: got %0d required 157", rise_cyc[0] - t_start); end
        checks++;
        if (n_vhi[0] - v0 !== 1) begin failures++; $display("FAIL 8n1_valid_width: got %0d required 1", n_vhi[0] - v0); end
        checks++;
        if (valid[0] !== 1'b0) begin failures++; $display("FAIL 8n1_valid_low: got %b required 0", valid[0]); end
    endtask

    task automatic test_parity_8e1;
        int a0;
        sel = 1;
        a0 = n_acc[1];
        send({5'd0, 1'b1, 1'b1, 8'h37, 1'b0}, 11, -1);
        tick(20);
        checks++;
        if (n_acc[1] - a0 !== 1) begin failures++; $display("FAIL 8e1_good_count: got %0d required 1", n_acc[1] - a0); end
        checks++;
        if (acc_dout[1] !== 8'h37) begin failures++; $display("FAIL 8e1_good_dout: got %h required 37", acc_dout[1]); end
        checks++;
        if (acc_perr[1] !== 1'b0) begin failures++; $display("FAIL 8e1_good_perr: got %b required 0", acc_perr[1]); end
        send({5'd0, 1'b1, 1'b0, 8'h37, 1'b0}, 11, -1);
        tick(20);
        checks++;
        if (n_acc[1] - a0 !== 2) begin failures++; $display("FAIL 8e1_bad_count: got %0d required 2", n_acc[1] - a0); end
        checks++;
        if (acc_dout[1] !== 8'h37) begin failures++; $display("FAIL 8e1_bad_dout: got %h required 37", acc_dout[1]); end
        checks++;
        if (acc_perr[1] !== 1'b1) begin failures++; $display("FAIL 8e1_bad_perr: got %b required 1", acc_perr[1]); end
        checks++;
        if (acc_ferr[1] !== 1'b0) begin failures++; $display("FAIL 8e1_bad_ferr: got %b required 0", acc_ferr[1]); end
        sel = 0;
    endtask

    task automatic test_back_to_back_overrun;
        int a0, o0;
        sel = 2;
        ready[2] = 1'b0;
        a0 = n_acc[2];
        o0 = n_ovr[2];
        send({4'd0, 2'b11, 8'h11, 1'b0}, 11, -1);
        send({4'd0, 2'b11, 8'h22, 1'b0}, 11, -1);
        tick(10);
        checks++;
        if (valid[2] !== 1'b1) begin failures++; $display("FAIL ovr_valid_held: got %b required 1", valid[2]); end
        checks++;
        if (dout[2] !== 8'h11) begin failures++; $display("FAIL ovr_dout_held: got %h required 11", dout[2]); end
        checks++;
        if (n_ovr[2] - o0 !== 1) begin failures++; $display("FAIL ovr_pulses: got %0d required 1", n_ovr[2] - o0); end
        checks++;
        if (n_acc[2] - a0 !== 0) begin failures++; $display("FAIL ovr_no_accept: got %0d required 0", n_acc[2] - a0); end
        ready[2] = 1'b1;
        tick(1);
        checks++;
        if (n_acc[2] - a0 !== 1 || acc_dout[2] !== 8'h11) begin
            failures++;
            $display("FAIL ovr_accept: got count %0d dout %h required 1 / 11", n_acc[2] - a0, acc_dout[2]);
        end
        checks++;
        if (valid[2] !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop: got %b required 0", valid[2]); end
        sel = 0;
    endtask

    task automatic test_false_start_glitch;
        int a0, v0, o0, b0;
        sel = 0;
        a0 = n_acc[0]; v0 = n_vhi[0]; o0 = n_ovr[0]; b0 = n_brk[0];
        line = 1'b0;
        tick(3);
        line = 1'b1;
        tick(2);
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL fs_busy_set: got %b required 1", busy[0]); end
        tick(30);
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL fs_busy_clear: got %b required 0", busy[0]); end
        checks++;
        if ((n_vhi[0] - v0) + (n_ovr[0] - o0) + (n_brk[0] - b0) !== 0) begin
            failures++;
            $display("FAIL fs_no_outputs: got %0d events required 0", (n_vhi[0] - v0) + (n_ovr[0] - o0) + (n_brk[0] - b0));
        end
        // Slot 73 = middle of data bit 3 (frame slot 16*4 + 9)
        send({6'd0, 1'b1, 8'hFF, 1'b0}, 10, 73);
        tick(20);
        checks++;
        if (n_acc[0] - a0 !== 1 || acc_dout[0] !== 8'hFF) begin
            failures++;
            $display("FAIL glitch_majority: got count %0d dout %h required 1 / ff", n_acc[0] - a0, acc_dout[0]);
        end
    endtask

    task automatic test_break;
        int b0;
        sel = 0;
        ready[0] = 1'b0;
        b0 = n_brk[0];
        line = 1'b0;
        tick(320);
        checks++;
        if (n_brk[0] - b0 !== 1) begin failures++; $display("FAIL brk_pulses: got %0d required 1", n_brk[0] - b0); end
        checks++;
        if (valid[0] !== 1'b0) begin failures++; $display("FAIL brk_valid: got %b required 0", valid[0]); end
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL brk_busy_low_line: got %b required 1", busy[0]); end
        line = 1'b1;
        tick(10);
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL brk_busy_short_high: got %b required 1", busy[0]); end
        tick(30);
        checks++;
        if (busy[0] !== 1'b0) begin failures++; $display("FAIL brk_busy_release: got %b required 0", busy[0]); end
        send({6'd0, 1'b1, 8'h5A, 1'b0}, 10, -1);
        tick(20);
        checks++;
        if (valid[0] !== 1'b1 || dout[0] !== 8'h5A) begin
            failures++;
            $display("FAIL brk_next_frame: got valid %b dout %h required 1 / 5a", valid[0], dout[0]);
        end
        checks++;
        if (n_brk[0] - b0 !== 1) begin failures++; $display("FAIL brk_single: got %0d required 1", n_brk[0] - b0); end
    endtask

    task automatic test_reset_midframe_and_ferr;
        logic [9:0] frame;
        int a0, b0;
        sel = 0;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 88; i++) begin
            line = frame[i / 16];
            tick(1);
        end
        rst = 1'b1;
        line = 1'b1;
        tick(1);
        checks++;
        if ({dout[0], valid[0], perr[0], ferr[0], ovr[0], brk[0], busy[0]} !== 14'd0) begin
            failures++;
            $display("FAIL midframe_reset: got %h required 0",
                     {dout[0], valid[0], perr[0], ferr[0], ovr[0], brk[0], busy[0]});
        end
        rst = 1'b0;
        tick(40);
        ready[0] = 1'b1;
        a0 = n_acc[0];
        b0 = n_brk[0];
        send({6'd0, 1'b1, 8'hC3, 1'b0}, 10, -1);
        tick(20);
        checks++;
        if (n_acc[0] - a0 !== 1 || acc_dout[0] !== 8'hC3) begin
            failures++;
            $display("FAIL after_reset_frame: got count %0d dout %h required 1 / c3", n_acc[0] - a0, acc_dout[0]);
        end
        send({6'd0, 1'b0, 8'h0F, 1'b0}, 10, -1);
        tick(20);
        checks++;
        if (acc_dout[0] !== 8'h0F) begin failures++; $display("FAIL ferr_dout: got %h required 0f", acc_dout[0]); end
        checks++;
        if (acc_ferr[0] !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b required 1", acc_ferr[0]); end
        checks++;
        if (n_brk[0] - b0 !== 0) begin failures++; $display("FAIL ferr_no_break: got %0d required 0", n_brk[0] - b0); end
    endtask

    initial begin
        ready[0] = 1'b1;
        ready[1] = 1'b1;
        ready[2] = 1'b1;
        test_reset();
        test_basic_8n1();
        test_parity_8e1();
        test_back_to_back_overrun();
        test_false_start_glitch();
        test_break();
        test_reset_midframe_and_ferr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
